// File: rtl/uart_axis_framer.sv
// UART byte stream to AXI-Stream framer: one header byte (tlast, tdest) followed by
// DATA_W/8 payload bytes, with a decoupled output register, break/timeout abort and error count.
module uart_axis_framer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEST_W  = 2,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_break,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_rx_data,
    output logic              uart_rx_en,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic [DEST_W-1:0] m_axis_tdest,
    output logic              frame_err,
    output logic [7:0]        err_count
);

    localparam int unsigned NB        = DATA_W / 8;
    localparam int unsigned BC_W      = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LIM    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic        TO_EN     = (TIMEOUT > 0);
    localparam logic [7:0]  RSVD_MASK = 8'(8'hFF << (DEST_W + 1));

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic                hdr_last_q, hdr_last_d;
    logic [DEST_W-1:0]   hdr_dest_q, hdr_dest_d;
    logic                tvalid_q, tvalid_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tlast_q, tlast_d;
    logic [DEST_W-1:0]   tdest_q, tdest_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic rx_take;
    logic hdr_ok;
    logic byte_last;
    logic out_free;
    logic to_hit;
    logic load_out;
    logic err_ev;

    assign rx_take   = uart_rx_valid && uart_rx_en;
    assign hdr_ok    = (uart_rx_data & RSVD_MASK) == 8'd0;
    assign byte_last = byte_cnt_q == BC_W'(NB - 1);
    assign out_free  = !tvalid_q || m_axis_tready;
    assign to_hit    = TO_EN && (to_cnt_q == TO_W'(TO_LIM));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; break beats a simultaneous byte
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HDR: begin
                if (rx_take && !uart_rx_break && hdr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (uart_rx_break || (!rx_take && to_hit)) begin
                    state_d = ST_HDR;
                end else if (rx_take && byte_last) begin
                    state_d = out_free ? ST_HDR : ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_free) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        uart_rx_en  = rst && (state_q != ST_FULL);
        byte_cnt_d  = byte_cnt_q;
        to_cnt_d    = to_cnt_q;
        asm_d       = asm_q;
        hdr_last_d  = hdr_last_q;
        hdr_dest_d  = hdr_dest_q;
        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        tdest_d     = tdest_q;
        load_out    = 1'b0;
        err_ev      = 1'b0;

        unique case (state_q)
            ST_HDR: begin
                if (rx_take && !uart_rx_break) begin
                    if (hdr_ok) begin
                        hdr_last_d = uart_rx_data[0];
                        hdr_dest_d = uart_rx_data[DEST_W:1];
                        byte_cnt_d = '0;
                        to_cnt_d   = '0;
                        asm_d      = '0;
                    end else begin
                        err_ev = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (uart_rx_break || (!rx_take && to_hit)) begin
                    err_ev     = 1'b1;
                    byte_cnt_d = '0;
                    to_cnt_d   = '0;
                    asm_d      = '0;
                end else if (rx_take) begin
                    for (int b = 0; b < int'(NB); b++) begin
                        if (byte_cnt_q == BC_W'(b)) begin
                            asm_d[8*b +: 8] = uart_rx_data;
                        end
                    end
                    to_cnt_d = '0;
                    if (byte_last) begin
                        byte_cnt_d = '0;
                        load_out   = out_free;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_FULL: begin
                load_out = out_free;
            end
            default: ;
        endcase

        tvalid_d = load_out || (tvalid_q && !m_axis_tready);
        if (load_out) begin
            tdata_d = asm_d;
            tlast_d = hdr_last_q;
            tdest_d = hdr_dest_q;
        end
        frame_err_d = err_ev;
        err_cnt_d   = (err_ev && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            asm_q       <= '0;
            hdr_last_q  <= 1'b0;
            hdr_dest_q  <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            tdest_q     <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            to_cnt_q    <= to_cnt_d;
            asm_q       <= asm_d;
            hdr_last_q  <= hdr_last_d;
            hdr_dest_q  <= hdr_dest_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tlast_q     <= tlast_d;
            tdest_q     <= tdest_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdest  = tdest_q;
    assign frame_err     = frame_err_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_uart_axis_framer.sv
// Scoreboard bench for uart_axis_framer (DATA_W=16, DEST_W=2, TIMEOUT=20).
`timescale 1ns/1ps
module tb_uart_axis_framer;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DEST_W  = 2;
    localparam int unsigned TIMEOUT = 20;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [DEST_W-1:0] dest;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              uart_rx_break = 1'b0;
    logic              uart_rx_valid = 1'b0;
    logic [7:0]        uart_rx_data = 8'd0;
    logic              uart_rx_en;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic [DEST_W-1:0] m_axis_tdest;
    logic              frame_err;
    logic [7:0]        err_count;

    uart_axis_framer #(
        .DATA_W (DATA_W),
        .DEST_W (DEST_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_break(uart_rx_break),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data),
        .uart_rx_en   (uart_rx_en),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tdest (m_axis_tdest),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    err_pulses = 0;
    int    total = 0;
    int    bad = 0;
    int    rd_idx = 0;
    int    exp_err = 0;

    // Observed handshakes and error pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (rst && m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tdest});
        end
        if (rst && frame_err) begin
            err_pulses++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        @(negedge clk);
        while (!uart_rx_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!uart_rx_en) begin
            bad++;
            $display("FAIL send_byte_timeout byte=%h uart_rx_en=%b required=1", b, uart_rx_en);
        end
        @(posedge clk);
        #1;
        uart_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 || m_axis_tdest !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b d=%h l=%b t=%0d required all 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest);
        end
        total++;
        if (frame_err !== 1'b0 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_err got frame_err=%b err_count=%0d required 0/0", frame_err, err_count);
        end
        total++;
        if (uart_rx_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_rx_en got=%b required=0", uart_rx_en);
        end
        rst = 1'b1;
        #1;
        total++;
        if (uart_rx_en !== 1'b1) begin
            bad++;
            $display("FAIL rx_en_after_reset got=%b required=1", uart_rx_en);
        end
        idle(1);
    endtask

    task automatic test_single();
        m_axis_tready = 1'b1;
        exp_q.push_back({16'h1234, 1'b1, 2'd2});
        send_byte(8'h05);
        send_byte(8'h34);
        send_byte(8'h12);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h1234 || m_axis_tlast !== 1'b1 || m_axis_tdest !== 2'd2) begin
            bad++;
            $display("FAIL single_first_cycle got v=%b d=%h l=%b t=%0d required 1/1234/1/2", m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest);
        end
        idle(1);
        total++;
        if (m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_one_cycle got tvalid=%b required=0", m_axis_tvalid);
        end
        while (rd_idx < obs_q.size()) begin
            beat_t e;
            total++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            if (obs_q[rd_idx] !== e) begin
                bad++;
                $display("FAIL single_beat got=%h required=%h", obs_q[rd_idx], e);
            end
            rd_idx++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL single_missing got pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        m_axis_tready = 1'b0;
        exp_q.push_back({16'hBBAA, 1'b0, 2'd1});
        exp_q.push_back({16'hDDCC, 1'b1, 2'd3});
        send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        send_byte(8'h07); send_byte(8'hCC); send_byte(8'hDD);
        idle(3);
        total++;
        if (uart_rx_en !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'hBBAA) begin
            bad++;
            $display("FAIL bp_hold got en=%b v=%b d=%h required 0/1/bbaa", uart_rx_en, m_axis_tvalid, m_axis_tdata);
        end
        m_axis_tready = 1'b1;
        idle(1);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'hDDCC || uart_rx_en !== 1'b1) begin
            bad++;
            $display("FAIL bp_second got v=%b d=%h en=%b required 1/ddcc/1", m_axis_tvalid, m_axis_tdata, uart_rx_en);
        end
        idle(1);
        total++;
        if (m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain got tvalid=%b required=0", m_axis_tvalid);
        end
        while (rd_idx < obs_q.size()) begin
            beat_t e;
            total++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            if (obs_q[rd_idx] !== e) begin
                bad++;
                $display("FAIL bp_beat got=%h required=%h", obs_q[rd_idx], e);
            end
            rd_idx++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_missing got pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_bad_header();
        send_byte(8'h18);
        exp_err++;
        total++;
        if (frame_err !== 1'b1 || err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL bad_hdr_err got frame_err=%b err_count=%0d required 1/%0d", frame_err, err_count, exp_err);
        end
        idle(1);
        total++;
        if (frame_err !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL bad_hdr_pulse got frame_err=%b tvalid=%b required 0/0", frame_err, m_axis_tvalid);
        end
        exp_q.push_back({16'h0201, 1'b0, 2'd0});
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        idle(2);
        while (rd_idx < obs_q.size()) begin
            beat_t e;
            total++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            if (obs_q[rd_idx] !== e) begin
                bad++;
                $display("FAIL bad_hdr_beat got=%h required=%h", obs_q[rd_idx], e);
            end
            rd_idx++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL bad_hdr_missing got pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        send_byte(8'h01);
        send_byte(8'h55);
        idle(TIMEOUT - 1);
        total++;
        if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early got frame_err=%b required=0", frame_err);
        end
        idle(1);
        exp_err++;
        total++;
        if (frame_err !== 1'b1 || err_count !== 8'(exp_err) || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_abort got frame_err=%b err_count=%0d tvalid=%b required 1/%0d/0", frame_err, err_count, m_axis_tvalid, exp_err);
        end
        exp_q.push_back({16'h2211, 1'b1, 2'd0});
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        idle(2);
        while (rd_idx < obs_q.size()) begin
            beat_t e;
            total++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            if (obs_q[rd_idx] !== e) begin
                bad++;
                $display("FAIL timeout_beat got=%h required=%h", obs_q[rd_idx], e);
            end
            rd_idx++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL timeout_missing got pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_break();
        send_byte(8'h01);
        send_byte(8'h77);
        uart_rx_break = 1'b1;
        idle(1);
        uart_rx_break = 1'b0;
        exp_err++;
        total++;
        if (frame_err !== 1'b1 || err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL break_data got frame_err=%b err_count=%0d required 1/%0d", frame_err, err_count, exp_err);
        end
        // Break with a byte in HDR: byte dropped, no error
        uart_rx_break = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h05;
        idle(1);
        uart_rx_break = 1'b0;
        uart_rx_valid = 1'b0;
        total++;
        if (frame_err !== 1'b0 || err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL break_hdr got frame_err=%b err_count=%0d required 0/%0d", frame_err, err_count, exp_err);
        end
        exp_q.push_back({16'h2010, 1'b1, 2'd1});
        send_byte(8'h03); send_byte(8'h10); send_byte(8'h20);
        m_axis_tready = 1'b0;
        idle(2);
        m_axis_tready = 1'b1;
        idle(1);
        m_axis_tready = 1'b0;
        exp_q.push_back({16'hBBAA, 1'b0, 2'd1});
        exp_q.push_back({16'hDDCC, 1'b1, 2'd1});
        send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        send_byte(8'h03); send_byte(8'hCC); send_byte(8'hDD);
        uart_rx_break = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            total++;
            if (frame_err !== 1'b0 || uart_rx_en !== 1'b0) begin
                bad++;
                $display("FAIL break_full got frame_err=%b en=%b required 0/0", frame_err, uart_rx_en);
            end
        end
        uart_rx_break = 1'b0;
        m_axis_tready = 1'b1;
        idle(3);
        total++;
        if (err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL break_full_count got=%0d required=%0d", err_count, exp_err);
        end
        while (rd_idx < obs_q.size()) begin
            beat_t e;
            total++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            if (obs_q[rd_idx] !== e) begin
                bad++;
                $display("FAIL break_beat got=%h required=%h", obs_q[rd_idx], e);
            end
            rd_idx++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL break_missing got pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_beat();
        m_axis_tready = 1'b0;
        send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        total++;
        if (m_axis_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre got tvalid=%b required=1", m_axis_tvalid);
        end
        rst = 1'b0;
        idle(1);
        exp_err = 0;
        total++;
        if (m_axis_tvalid !== 1'b0 || err_count !== 8'd0 || uart_rx_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got v=%b err_count=%0d en=%b required 0/0/0", m_axis_tvalid, err_count, uart_rx_en);
        end
        rst = 1'b1;
        m_axis_tready = 1'b1;
        idle(1);
        exp_q.push_back({16'h1234, 1'b1, 2'd2});
        send_byte(8'h05); send_byte(8'h34); send_byte(8'h12);
        idle(2);
        while (rd_idx < obs_q.size()) begin
            beat_t e;
            total++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            if (obs_q[rd_idx] !== e) begin
                bad++;
                $display("FAIL rst_mid_beat got=%h required=%h", obs_q[rd_idx], e);
            end
            rd_idx++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_missing got pending=%0d required=0", exp_q.size());
        end
        total++;
        if (err_pulses != 3) begin
            bad++;
            $display("FAIL err_pulse_total got=%0d required=3", err_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_bad_header();
        test_timeout();
        test_break();
        test_reset_mid_beat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_axis_framer.md
Name: uart_axis_framer

Overview:
- Converts the UART receive byte stream into AXI-Stream words for the switch.
- Each frame is one header byte followed by DATA_W/8 payload bytes.
- The header carries the TLAST flag and a TDEST channel number.
- Adds over the single-byte framer: parametrised word width, destination routing, a decoupled output register with back-pressure to the UART, break/timeout abort, and error reporting.

Parameters:
- DATA_W, 8: output word width in bits. Must be a multiple of 8, range 8..64. NB = DATA_W/8 bytes per word.
- DEST_W, 2: TDEST width, range 1..6. Header bits [DEST_W:1] carry the destination.
- TIMEOUT, 100000: idle clk cycles allowed between payload bytes before the frame is aborted. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- uart_rx_break  in  1  UART break detected; aborts a partial frame
- uart_rx_valid  in  1  UART byte available
- uart_rx_data  in  8  UART byte
- uart_rx_en  out  1  framer accepts a byte this cycle; a byte is taken when uart_rx_valid && uart_rx_en
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  switch ready
- m_axis_tdata  out  DATA_W  output word
- m_axis_tlast  out  1  last word of packet
- m_axis_tdest  out  DEST_W  destination channel
- frame_err  out  1  one-cycle pulse on any frame abort or rejected header
- err_count  out  8  saturating count of frame_err pulses

Behaviour:
- Reset (rst=0 at clk edge):
  - state=HDR; byte counter, timeout counter, assembly and output registers cleared.
  - m_axis_tvalid=0, tdata=0, tlast=0, tdest=0, frame_err=0, err_count=0.
  - uart_rx_en is forced 0 while rst=0.
  - Reset mid-beat drops the word; tvalid is 0 from the next edge.
- Header byte H:
  - last = H[0]; dest = H[DEST_W:1].
  - Bits [7:DEST_W+1] are reserved and must be 0.
  - If any reserved bit is set: discard H, pulse frame_err, increment err_count, stay in HDR.
- State machine:
  - HDR: uart_rx_en=1. On an accepted valid header: latch last/dest, byte_cnt=0, go to DATA.
  - DATA: uart_rx_en=1. An accepted byte writes to asm[8*byte_cnt+7 : 8*byte_cnt] (first byte = LSBs) and resets the timeout counter. On byte NB-1:
    - if the output register is free, or is being emptied this cycle (tvalid && tready), load it and go to HDR;
    - otherwise go to FULL.
  - FULL: uart_rx_en=0. When the output register becomes free (tvalid=0, or tvalid && tready), transfer asm/last/dest into it and go to HDR.
- Output latency:
  - tvalid rises on the edge that latches the last payload byte (first cycle after acceptance) when the output is free.
  - At most one word is held in asm plus one in the output register. No byte is ever dropped while uart_rx_en=1.
- AXIS rules:
  - tdata/tlast/tdest stay stable while tvalid && !tready.
  - tvalid drops after the handshake unless a new word loads on the same edge; back-to-back beats are allowed.
  - tlast is per word, exactly as given by that frame's header bit 0.
- Timeout:
  - Applies only in DATA with TIMEOUT>0.
  - The counter increments on each cycle with no accepted byte.
  - When it reaches TIMEOUT: discard the partial word, go to HDR, pulse frame_err, increment err_count.
- Break (uart_rx_break=1):
  - In DATA: abort as for timeout, with frame_err.
  - In HDR: no error; any byte that cycle is discarded.
  - In FULL: ignored, since the word is complete.
  - Break wins over a simultaneous uart_rx_valid.
- err_count saturates at 255. frame_err is asserted for exactly one cycle per event.
- NB=1 (DATA_W=8): each frame is header plus one byte. This matches the legacy framing, with tlast per word and no 1-cycle tlast leakage onto the following word.

Test Plan:
All scenarios use DATA_W=16, DEST_W=2, TIMEOUT=20.
1. Bytes 0x05, 0x34, 0x12 with tready=1 -> one beat: tdata=0x1234, tdest=2, tlast=1. tvalid is high for exactly 1 cycle, starting the cycle after 0x12 is accepted.
2. tready=0; frames (0x02,0xAA,0xBB) then (0x07,0xCC,0xDD) -> uart_rx_en=0 after 0xDD. Raise tready -> beats 0xBBAA (dest1, last0) then 0xDDCC (dest3, last1) on consecutive cycles; uart_rx_en returns to 1.
3. Header 0x18 (reserved bit set) -> frame_err pulse, err_count=1, no beat, state stays HDR. A following valid frame (0x00,0x01,0x02) -> tdata=0x0201.
4. Header 0x01, byte 0x55, then 20 idle cycles -> frame_err, err_count+1, no beat. Next bytes 0x01,0x11,0x22 -> tdata=0x2211, tlast=1.
5. Break after the first payload byte -> abort with frame_err. Break while in FULL -> no error; the held word is still delivered intact.
6. Reset asserted while tvalid=1 && tready=0 -> tvalid=0, err_count=0 next cycle. After release, a fresh frame is delivered normally.
